// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a multi-digit 7-segment display with a
// shadow/active register bank, frame-aligned commit, blanking and leading-zero suppression.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_value,
    input  logic                          wr_dp,
    input  logic                          wr_blank,
    input  logic                          commit,
    input  logic                          lzs_en,
    output logic                          commit_pending,
    output logic                          frame_tick,
    output logic [7:0]                    seg_n,
    output logic [NUM_DIGITS-1:0]         dig_n
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [AW-1:0] IDX_MAX = AW'(NUM_DIGITS - 1);

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;

    logic [3:0] sh_value  [NUM_DIGITS];
    logic       sh_dp     [NUM_DIGITS];
    logic       sh_blank  [NUM_DIGITS];
    logic [3:0] act_value [NUM_DIGITS];
    logic       act_dp    [NUM_DIGITS];
    logic       act_blank [NUM_DIGITS];

    logic                  slot_end;
    logic                  fb;
    logic                  wr_ok;
    phase_t                phase;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic                  suppressed;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] dig_next;

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h67;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_MAX);
    assign fb       = slot_end && (idx == IDX_MAX);
    assign wr_ok    = wr_en && (int'(wr_addr) < NUM_DIGITS);
    assign phase    = (int'(cnt) < BLANK_CYCLES) ? PH_BLANK : PH_ON;

    // lead_zero[i]: digit i and every digit above it show a plain zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (act_value[i] == 4'h0) && !act_dp[i];
            lead_zero[i] = zero_run;
        end
    end

    assign suppressed = act_blank[idx] || (lzs_en && lead_zero[idx] && (idx != '0));

    always_comb begin
        seg_next = 8'hFF;
        dig_next = '1;
        if (phase == PH_ON && !suppressed) begin
            seg_next = ~{act_dp[idx], pat(act_value[idx])};
            dig_next = ~(NUM_DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // wr_en and commit are strobes without back-pressure: each is accepted in
    // the cycle it is high, there is no ready and no retry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sh_value[i]  <= 4'h0;
                sh_dp[i]     <= 1'b0;
                sh_blank[i]  <= 1'b1;
                act_value[i] <= 4'h0;
                act_dp[i]    <= 1'b0;
                act_blank[i] <= 1'b1;
            end
            commit_pending <= 1'b0;
        end else begin
            if (wr_ok) begin
                sh_value[wr_addr] <= wr_value;
                sh_dp[wr_addr]    <= wr_dp;
                sh_blank[wr_addr] <= wr_blank;
            end
            // A commit landing on the boundary itself queues the next frame's copy.
            if (fb && commit_pending) begin
                act_value      <= sh_value;
                act_dp         <= sh_dp;
                act_blank      <= sh_blank;
                commit_pending <= commit;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n      <= 8'hFF;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dig_n      <= dig_next;
            frame_tick <= fb;
        end
    end

endmodule
